// File: rtl/rtc_bus_phase_driver_if.sv
// Requester handshake plus the physical RTC multiplexed-bus pins for one phase driver.
// slave = the phase driver itself; master = the requester and RTC pin model around it.
interface rtc_bus_phase_driver_if;
    logic       req;
    logic       a_d;
    logic       w_r;
    logic [7:0] din;
    logic [7:0] dout;
    logic       busy;
    logic       done;
    logic [7:0] bus_in;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic       cs_n;
    logic       ad_pin;
    logic       wr_n;
    logic       rd_n;

    modport slave (
        input  req, a_d, w_r, din, bus_in,
        output dout, busy, done, bus_out, bus_oe, cs_n, ad_pin, wr_n, rd_n
    );

    modport master (
        output req, a_d, w_r, din, bus_in,
        input  dout, busy, done, bus_out, bus_oe, cs_n, ad_pin, wr_n, rd_n
    );
endinterface

// File: rtl/rtc_bus_phase_driver.sv
// Drives one address or data byte phase on the RTC multiplexed AD bus:
// setup, strobe, hold and recover timing from a single shared down counter.
module rtc_bus_phase_driver #(
    parameter int unsigned SETUP_CYC   = 2,
    parameter int unsigned PULSE_CYC   = 5,
    parameter int unsigned HOLD_CYC    = 2,
    parameter int unsigned RECOVER_CYC = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    rtc_bus_phase_driver_if.slave bus
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        RECOVER
    } state_e;

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                we_q;
    logic                cs_n_q;
    logic                wr_n_q;
    logic                rd_n_q;
    logic                ad_pin_q;
    logic                bus_oe_q;
    logic [BYTE_W-1:0]   bus_out_q;
    logic [BYTE_W-1:0]   dout_q;
    logic                busy_q;
    logic                done_q;

    logic                accept_c;
    logic                eff_we_c;
    logic                cnt_zero_c;

    // The last RECOVER cycle accepts directly so back-to-back phases keep a fixed period.
    assign cnt_zero_c = (cnt_q == CNT_W'(0));
    assign accept_c   = bus.req && ((state_q == IDLE) || ((state_q == RECOVER) && cnt_zero_c));
    assign eff_we_c   = bus.w_r | ~bus.a_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= CNT_W'(0);
            we_q      <= 1'b0;
            cs_n_q    <= 1'b1;
            wr_n_q    <= 1'b1;
            rd_n_q    <= 1'b1;
            ad_pin_q  <= 1'b0;
            bus_oe_q  <= 1'b0;
            bus_out_q <= BYTE_W'(0);
            dout_q    <= BYTE_W'(0);
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept_c) begin
                state_q   <= SETUP;
                cnt_q     <= CNT_W'(SETUP_CYC - 1);
                we_q      <= eff_we_c;
                ad_pin_q  <= bus.a_d;
                cs_n_q    <= 1'b0;
                busy_q    <= 1'b1;
                bus_oe_q  <= eff_we_c;
                bus_out_q <= eff_we_c ? bus.din : BYTE_W'(0);
            end else begin
                case (state_q)
                    IDLE: state_q <= IDLE;
                    SETUP: begin
                        if (cnt_zero_c) begin
                            state_q <= STROBE;
                            cnt_q   <= CNT_W'(PULSE_CYC - 1);
                            wr_n_q  <= ~we_q;
                            rd_n_q  <= we_q;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    STROBE: begin
                        if (cnt_zero_c) begin
                            state_q <= HOLD;
                            cnt_q   <= CNT_W'(HOLD_CYC - 1);
                            wr_n_q  <= 1'b1;
                            rd_n_q  <= 1'b1;
                            if (!we_q) begin
                                dout_q <= bus.bus_in;
                            end
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    HOLD: begin
                        if (cnt_zero_c) begin
                            state_q  <= RECOVER;
                            cnt_q    <= CNT_W'(RECOVER_CYC - 1);
                            cs_n_q   <= 1'b1;
                            bus_oe_q <= 1'b0;
                            done_q   <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    RECOVER: begin
                        if (cnt_zero_c) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        cnt_q   <= CNT_W'(0);
                    end
                endcase
            end
        end
    end

    assign bus.cs_n    = cs_n_q;
    assign bus.wr_n    = wr_n_q;
    assign bus.rd_n    = rd_n_q;
    assign bus.ad_pin  = ad_pin_q;
    assign bus.bus_oe  = bus_oe_q;
    assign bus.bus_out = bus_out_q;
    assign bus.dout    = dout_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule

// File: doc/rtc_bus_phase_driver.md
# rtc_bus_phase_driver

Drives the RTC's multiplexed address/data parallel bus for one byte phase per request. Sits directly downstream of the per-field edit machines (month, day, hour, ...): they present an A/D select, a write/read select and a byte, and this block turns that into a correctly timed chip-select / strobe sequence on the physical RTC pins. Read phases return the sampled bus byte to the requester. One phase is in flight at a time; the requester waits on `busy`/`done`.

## Interface
Parameters:
- `SETUP_CYC`, 2: cycles of `cs_n` low with A/D and bus valid before the strobe falls (1..15)
- `PULSE_CYC`, 5: cycles the `wr_n`/`rd_n` strobe stays low (1..15)
- `HOLD_CYC`, 2: cycles after the strobe rises with `cs_n` still low and the bus still driven (1..15)
- `RECOVER_CYC`, 3: cycles with `cs_n` high before a new request is accepted (1..15)

Ports:
- `clk`  in  1  system clock; single clock domain
- `reset`  in  1  synchronous, active-high reset
- `req`  in  1  start a phase; sampled only in IDLE
- `a_d`  in  1  0 = address phase, 1 = data phase
- `w_r`  in  1  1 = write, 0 = read; ignored (forced write) when `a_d`=0
- `din`  in  8  address or write-data byte
- `bus_in`  in  8  RTC AD bus, input side of the tristate
- `bus_out`  out  8  RTC AD bus, output side
- `bus_oe`  out  1  1 = drive `bus_out` onto the pins
- `cs_n`  out  1  RTC chip select, active low
- `ad_pin`  out  1  RTC A/D pin, follows latched `a_d`
- `wr_n`  out  1  write strobe, active low
- `rd_n`  out  1  read strobe, active low
- `dout`  out  8  byte sampled on the last read
- `busy`  out  1  high from acceptance until return to IDLE
- `done`  out  1  one-cycle pulse at end of a phase

## Operation
- All outputs registered. Reset values: `cs_n`=1, `wr_n`=1, `rd_n`=1, `ad_pin`=0, `bus_oe`=0, `bus_out`=0x00, `dout`=0x00, `busy`=0, `done`=0; state IDLE, counter 0.
- States: IDLE, SETUP, STROBE, HOLD, RECOVER. One 4-bit down counter shared by all timed states.
- IDLE: `req`=1 at an edge latches `a_d`, effective write (`w_r | ~a_d`) and `din`; -> SETUP, counter = SETUP_CYC-1. `req`=0 stays in IDLE.
- SETUP: `cs_n`=0, `ad_pin`=latched a_d, write: `bus_oe`=1 with latched byte; read: `bus_oe`=0. Counter 0 -> STROBE, counter = PULSE_CYC-1.
- STROBE: `wr_n`=0 (write) or `rd_n`=0 (read); exactly one strobe low, never both. Read: `bus_in` captured into `dout` at the edge that ends the last STROBE cycle. Counter 0 -> HOLD, counter = HOLD_CYC-1.
- HOLD: strobes high, `cs_n`=0, write keeps `bus_oe`=1 and byte. Counter 0 -> RECOVER, counter = RECOVER_CYC-1.
- RECOVER: `cs_n`=1, `bus_oe`=0, `ad_pin` holds. `done`=1 in its first cycle only. Counter 0 -> IDLE.
- `req` outside IDLE is ignored, not queued. Inputs `a_d`/`w_r`/`din` may change after acceptance without effect.
- `reset` in any state: at that edge all outputs return to reset values, state IDLE; no `done` for the aborted phase; `dout` cleared.
- `bus_oe` never 1 while `rd_n`=0.

## Timing
- Request accepted at edge k: `cs_n`, `busy`, `ad_pin`, `bus_oe` valid from edge k (registered, visible in cycle k+1).
- `cs_n` low for SETUP_CYC+PULSE_CYC+HOLD_CYC cycles; strobe low for PULSE_CYC cycles, starting SETUP_CYC cycles after `cs_n` falls.
- `done` high in the cycle right after `cs_n` rises; `dout` valid when `done`=1 and stable until next read or reset.
- `busy` high for SETUP+PULSE+HOLD+RECOVER cycles (defaults: 12). Earliest next acceptance is the edge at which `busy` drops, i.e. back-to-back phases every 12 cycles with `req` held high.

## Test plan
- Reset: hold `reset` 2 cycles -> all outputs at reset values, `busy`=0, `cs_n`=1.
- Address write: `a_d`=0, `w_r`=0, `din`=0x25, 1-cycle `req` -> forced write; `cs_n` low 9 cycles, `wr_n` low cycles 3-7 of that window, `bus_out`=0x25 with `bus_oe`=1 throughout, `rd_n` stays 1, `done` pulse once, `busy` 12 cycles.
- Data read: `a_d`=1, `w_r`=0, model drives `bus_in`=0x04 only while `rd_n`=0 -> `rd_n` low 5 cycles, `bus_oe`=0 whole phase, `dout`=0x04 at `done`.
- Back-to-back: address 0x25 then data write 0x11 with `req` held high -> second `cs_n` fall exactly 3 cycles after first rises; no overlap, `din` changes during phase 1 do not corrupt `bus_out`.
- Ignored request: pulse `req` during STROBE -> no extra phase, exactly one `done`.
- Mid-phase reset: assert `reset` in cycle 4 of a write -> next edge `wr_n`=1, `cs_n`=1, `bus_oe`=0, `busy`=0, no `done`; new request afterwards completes normally.
